reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
- Round-robin controller that shares one bank of NREGS 16-bit load-enabled registers (reg16 instances) between NREQ requesters.
- Each requester issues single read or write transactions over a valid/ready handshake. The block sequences the bank's load strobes and data input, and returns a per-requester response.
- Sits between the datapath masters (CPU core, DMA/debug port) and the general-purpose register bank.

Parameters:
NREQ, 2, number of requesters (2..4)
NREGS, 8, registers in the bank (power of two, 2..16)
WIDTH, 16, register data width
ADDR_W, $clog2(NREGS), derived register address width (localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock; asynchronous, active-low
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (combinational)
req_we  input  NREQ  1 = write, 0 = read
req_addr  input  NREQ*ADDR_W  register index, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NREQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
rsp_valid  output  NREQ  one-cycle completion pulse to owning requester
rsp_rdata  output  WIDTH  read data (write data echoed for writes), valid while any rsp_valid is high
bank_in  output  WIDTH  data to all bank register inputs
bank_load  output  NREGS  one-hot load strobe per bank register
bank_out  input  NREGS*WIDTH  bank register outputs, register r at [r*WIDTH +: WIDTH]
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; bank_load, rsp_valid, bank_in, rsp_rdata, latched owner/addr/we/data all 0.
  - RR pointer (last_grant) = NREQ-1, so requester 0 has top priority first.
- FSM IDLE -> EXEC -> RESP -> IDLE. One transaction per 3 cycles; no pipelining.
- IDLE:
  - Winner = first i with req_valid[i], searching from last_grant+1 modulo NREQ.
  - req_ready[winner] = 1 combinationally; all other req_ready = 0.
  - If any valid: at the clock edge, latch winner's we/addr/wdata, set last_grant = winner, go to EXEC.
  - No valid: stay IDLE; req_ready all 0.
- EXEC (one cycle):
  - Write: bank_in = latched wdata; bank_load[addr] = 1 (registered, exactly one bit); the bank captures at the edge ending EXEC.
  - Read: bank_load = 0; bank_out[addr] is sampled into rsp_rdata at the edge ending EXEC.
  - Next state RESP.
- RESP (one cycle):
  - rsp_valid[owner] = 1; rsp_rdata = read value or echoed write data; bank_load = 0.
  - Next state IDLE.
- req_ready is 0 in EXEC and RESP. Requesters hold valid/we/addr/wdata stable until accepted.
  - Changing these while valid and not ready is a protocol violation; behaviour is unspecified but the FSM must not hang.
- Read after write to the same register (any requesters) returns the new value: the write lands before the next IDLE accept.
- bank_in holds its last value outside EXEC. Only bank_load qualifies writes.
- A requester may re-request in the IDLE cycle after its RESP; it is still subject to round-robin.
- Under continuous requests from all, grants rotate 0,1,..,NREQ-1,0; no requester waits more than NREQ transactions.
- Reset mid-transaction:
  - Asserted during EXEC: bank_load drops immediately; the write is lost if rst_n falls before the EXEC-ending edge. No rsp_valid is issued.
  - After release: IDLE, pointer reset.
- bank_load is never multi-hot and never high outside EXEC.

Test Plan:
- Reset: drive rst_n low mid-cycle -> all outputs 0 asynchronously, busy=0; after release req0 valid alone -> req_ready=01 in first IDLE cycle.
- Single write/read: req0 write addr 3 data 0xBEEF; then req0 read addr 3 -> bank_load=0x08 for exactly one cycle, rsp_valid[0] pulses 2 cycles after accept, read rsp_rdata=0xBEEF.
- Contention: req0 and req1 valid same cycle from reset -> req0 granted first, req1 next; req0 immediately re-requests -> order 0,1,0, each transaction 3 cycles.
- Read-after-write across requesters: req1 writes addr 7 = 0x1234 while req0 waits to read addr 7 -> req0 gets 0x1234.
- Stall: req1 valid held while busy -> req_ready[1]=0 in EXEC/RESP, accepted in next IDLE, valid never dropped.
- Reset mid-EXEC of write 0xAAAA to addr 2 -> bank_load falls immediately, no rsp_valid, reg2 unchanged, FSM idle after release.

Source files
------------

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bus of the register-bank arbiter: per-requester request
// handshake plus the shared response channel.
interface reg_bank_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int NREGS = 8,
    parameter int WIDTH = 16
);
    localparam int ADDR_W = $clog2(NREGS);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [WIDTH-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one bank of load-enabled registers between
// NREQ requesters; one transaction per IDLE -> EXEC -> RESP pass.
module reg_bank_arbiter #(
    parameter int NREQ  = 2,
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_bank_arbiter_if.slave      bus,
    output logic [WIDTH-1:0]       bank_in,
    output logic [NREGS-1:0]       bank_load,
    input  logic [NREGS*WIDTH-1:0] bank_out,
    output logic                   busy
);
    localparam int ADDR_W = $clog2(NREGS);
    localparam int GW     = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       owner;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [WIDTH-1:0]    wdata_q;
    logic [NREQ-1:0]     rsp_valid_q;
    logic [WIDTH-1:0]    rsp_rdata_q;
    logic                win_found;
    logic [GW-1:0]       win_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [WIDTH-1:0]    win_wdata;

    // First valid requester after the last grant, wrapping; MSB flags a hit.
    function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [GW-1:0]   last);
        logic [GW:0] res;
        int          idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (v[idx]) res = {1'b1, GW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [NREGS-1:0] dec_onehot(input logic [ADDR_W-1:0] a);
        logic [NREGS-1:0] oh;
        oh    = '0;
        oh[a] = 1'b1;
        return oh;
    endfunction

    assign {win_found, win_idx} = rr_pick(bus.req_valid, last_grant);
    assign win_addr  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_wdata = bus.req_wdata[win_idx*WIDTH +: WIDTH];

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && win_found) bus.req_ready[win_idx] = 1'b1;
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered so bank_load is high for exactly the EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= GW'(NREQ - 1);
            owner       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            bank_in     <= '0;
            bank_load   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            bank_load   <= '0;
            rsp_valid_q <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner      <= win_idx;
                        last_grant <= win_idx;
                        we_q       <= bus.req_we[win_idx];
                        addr_q     <= win_addr;
                        wdata_q    <= win_wdata;
                        if (bus.req_we[win_idx]) begin
                            bank_in   <= win_wdata;
                            bank_load <= dec_onehot(win_addr);
                        end
                    end
                end
                EXEC: begin
                    rsp_valid_q[owner] <= 1'b1;
                    rsp_rdata_q        <= we_q ? wdata_q
                                               : bank_out[addr_q*WIDTH +: WIDTH];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Randomized scoreboard bench for reg_bank_arbiter with a behavioural
// register-file and round-robin model plus directed reset scenarios.
module tb_reg_bank_arbiter;
    localparam int NREQ   = 2;
    localparam int NREGS  = 8;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = $clog2(NREGS);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } cmd_t;

    typedef struct packed {
        logic [NREQ-1:0]  owner;
        logic [WIDTH-1:0] data;
        logic [31:0]      due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.NREQ(NREQ), .NREGS(NREGS), .WIDTH(WIDTH)) bus ();

    logic [WIDTH-1:0]       bank_in;
    logic [NREGS-1:0]       bank_load;
    logic [NREGS*WIDTH-1:0] bank_out;
    logic                   busy;

    reg_bank_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .bank_in   (bank_in),
        .bank_load (bank_load),
        .bank_out  (bank_out),
        .busy      (busy)
    );

    // Register bank the arbiter drives (not reset by rst_n)
    logic [WIDTH-1:0] bank [NREGS];
    logic             bank_clr = 1'b1;
    always @(posedge clk)
        for (int r = 0; r < NREGS; r++)
            if (bank_clr) bank[r] <= '0;
            else if (bank_load[r]) bank[r] <= bank_in;
    for (genvar r = 0; r < NREGS; r++) begin : g_bo
        assign bank_out[r*WIDTH +: WIDTH] = bank[r];
    end

    logic [NREQ-1:0]        rv = '0;
    logic [NREQ-1:0]        rwe = '0;
    logic [NREQ*ADDR_W-1:0] raddr = '0;
    logic [NREQ*WIDTH-1:0]  rwd = '0;
    assign bus.req_valid = rv;
    assign bus.req_we    = rwe;
    assign bus.req_addr  = raddr;
    assign bus.req_wdata = rwd;

    // Reference model state
    logic [WIDTH-1:0] mem [NREGS];
    int               last = NREQ - 1;
    int               left = 0;
    logic [NREGS-1:0] exp_load = '0;
    logic [NREQ-1:0]  acc = '0;
    cmd_t             cmdq [NREQ][$];
    rsp_t             sb [$];
    int               grants [$];
    int               gcyc [$];
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_winner(input logic [NREQ-1:0] v, input int lst);
        for (int k = 1; k <= NREQ; k++)
            if (v[(lst + k) % NREQ]) return (lst + k) % NREQ;
        return -1;
    endfunction

    task automatic push_cmd(input int r, input bit we, input int addr, input int data);
        cmd_t c;
        c.we   = we;
        c.addr = ADDR_W'(addr);
        c.data = WIDTH'(data);
        cmdq[r].push_back(c);
    endtask

    task automatic step();
        cmd_t            c;
        int              w;
        logic [NREQ-1:0] exp_rdy;
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
        rsp_t            e;
        @(negedge clk);
        if (left > 0) left--;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                rv[i]  = 1'b0;
                acc[i] = 1'b0;
            end
            if (!rv[i] && cmdq[i].size() > 0) begin
                c = cmdq[i].pop_front();
                rv[i]  = 1'b1;
                rwe[i] = c.we;
                raddr[i*ADDR_W +: ADDR_W] = c.addr;
                rwd[i*WIDTH +: WIDTH]     = c.data;
            end
        end
        #1;
        chk("busy", busy, left > 0);
        chk("bank_load", bank_load, (left == 2) ? exp_load : '0);
        w       = (left == 0) ? ref_winner(rv, last) : -1;
        exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
        chk("req_ready", bus.req_ready, exp_rdy);
        if (w >= 0) begin
            acc[w] = 1'b1;
            grants.push_back(w);
            gcyc.push_back(cyc);
            last = w;
            left = 3;
            a = raddr[w*ADDR_W +: ADDR_W];
            d = rwd[w*WIDTH +: WIDTH];
            if (rwe[w]) begin
                mem[a]   = d;
                exp_load = NREGS'(1) << a;
                e.data   = d;
            end else begin
                exp_load = '0;
                e.data   = mem[a];
            end
            e.owner = NREQ'(1) << w;
            e.due   = 32'(cyc + 2);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (((|rv) || cmdq[0].size() > 0 || cmdq[1].size() > 0 || left > 0
                || sb.size() > 0) && n < 500) begin
            step();
            n++;
        end
        chk("drain_timeout_pending", 32'(sb.size()), 0);
    endtask

    task automatic model_reset();
        last     = NREQ - 1;
        left     = 0;
        acc      = '0;
        rv       = '0;
        exp_load = '0;
    endtask

    // Scoreboard monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (|bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, '0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", bus.rsp_valid, e.owner);
                    chk("rsp_rdata", bus.rsp_rdata, e.data);
                    chk("rsp_latency", 32'(cyc), e.due);
                end
            end else if (sb.size() > 0 && e.due <= 32'(cyc) && sb[0].due <= 32'(cyc)) begin
                chk("rsp_missing", bus.rsp_valid, sb[0].owner);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < NREGS; r++) mem[r] = '0;
        repeat (3) @(negedge clk);
        bank_clr = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_bank_load", bank_load, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_bank_in", bank_in, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        rst_n = 1'b1;

        // Single write then read on requester 0
        push_cmd(0, 1'b1, 3, 16'hBEEF);
        push_cmd(0, 1'b0, 3, 0);
        wait_done();
        chk("bank3_beef", bank[3], 16'hBEEF);

        // Contention from reset: order 0,1,0 at 3-cycle spacing
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        grants.delete();
        gcyc.delete();
        push_cmd(0, 1'b0, 3, 0);
        push_cmd(0, 1'b1, 5, 16'h5555);
        push_cmd(1, 1'b0, 1, 0);
        wait_done();
        chk("grant_count", 32'(grants.size()), 3);
        if (grants.size() == 3) begin
            chk("grant_0", grants[0], 0);
            chk("grant_1", grants[1], 1);
            chk("grant_2", grants[2], 0);
            chk("grant_gap_a", 32'(gcyc[1] - gcyc[0]), 3);
            chk("grant_gap_b", 32'(gcyc[2] - gcyc[1]), 3);
        end

        // Read-after-write across requesters (pointer now favours req1)
        push_cmd(1, 1'b1, 7, 16'h1234);
        push_cmd(0, 1'b0, 7, 0);
        wait_done();
        chk("bank7_1234", bank[7], 16'h1234);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (cmdq[i].size() < 2 && $urandom_range(0, 3) == 0)
                    push_cmd(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)),
                             int'($urandom_range(0, 16'hFFFF)));
            step();
        end
        wait_done();

        // Reset during EXEC of a write to reg 2
        @(negedge clk);
        rv[0] = 1'b1;
        rwe[0] = 1'b1;
        raddr[0 +: ADDR_W] = ADDR_W'(2);
        rwd[0 +: WIDTH]    = 16'hAAAA;
        #1;
        chk("exec_rst_ready", bus.req_ready, 2'b01);
        @(negedge clk);
        rv = '0;
        #1;
        chk("exec_load_hi", bank_load, 8'h04);
        chk("exec_bank_in", bank_in, 16'hAAAA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("exec_rst_load", bank_load, 0);
        chk("exec_rst_busy", busy, 0);
        chk("exec_rst_bank_in", bank_in, 0);
        chk("exec_rst_rdata", bus.rsp_rdata, 0);
        repeat (3) @(negedge clk);
        chk("exec_rst_rsp", bus.rsp_valid, 0);
        chk("reg2_kept", bank[2], mem[2]);
        model_reset();
        rst_n = 1'b1;
        push_cmd(0, 1'b0, 2, 0);
        push_cmd(1, 1'b0, 2, 0);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
